// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares the register file's single 16:1 read port among NUM_REQ requesters.
// Round-robin grant (at most one per cycle), combinational mux select in the
// grant cycle, and a one-cycle registered response slice per requester.
//
// Optional build macro: RF_ARB_BYPASS_EN
//   defined   -> a write to the granted address in the grant cycle is
//                forwarded into the response (write-to-read bypass)
//   undefined -> the response always takes rf_data_i (old contents on a
//                same-cycle collision); the write ports are left unused.
//
// Handshake (valid/ready): requester k raises req_valid_i[k] with a stable
// req_addr_i slice k and holds both until it sees req_ready_o[k]=1 in the
// same cycle. That cycle is the transfer. It may drop valid (or present a new
// address) from the following cycle. The response for a transfer in cycle T
// appears as a one-cycle rsp_valid_o[k] pulse in cycle T+1, with the word
// held in rsp_data_o slice k until the next transfer for k.

module regfile_read_arbiter #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [4*NUM_REQ-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [3:0]             rf_sel_o,
    input  logic [N-1:0]           rf_data_i,
    input  logic                   wr_en_i,
    input  logic [3:0]             wr_addr_i,
    input  logic [N-1:0]           wr_data_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    output logic [N*NUM_REQ-1:0]   rsp_data_o,
    output logic                   busy_o
);

    // Pointer width; one extra bit is used for the wrap arithmetic.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = NUM_REQ[PTR_W:0];

    // Modular add of two in-range indices; the sum is below 2*NUM_REQ so a
    // single conditional subtraction brings it back into range.
    function automatic logic [PTR_W-1:0] wrap_add(
        input logic [PTR_W-1:0] base,
        input logic [PTR_W-1:0] off
    );
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        return sum[PTR_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic               busy_q;
    logic [N-1:0]       rsp_q [NUM_REQ];

    // ------------------------------------------------------------------
    // Per-requester address view of the flat address bus
    // ------------------------------------------------------------------
    logic [3:0] req_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g]           = req_addr_i[4*g +: 4];
        assign rsp_data_o[N*g +: N]  = rsp_q[g];
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant_vec;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_hit;
    logic [3:0]         grant_sel;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   next_ptr;

    // Scan from rr_ptr upward (wrapping) and pick the first valid requester;
    // reset forces no grant and a zero select.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_hit = 1'b0;
        grant_sel = '0;
        cand      = '0;
        if (!rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = wrap_add(rr_ptr, PTR_W'(i));
                if (!grant_hit && req_valid_i[cand]) begin
                    grant_hit = 1'b1;
                    grant_idx = cand;
                end
            end
            if (grant_hit) begin
                grant_vec[grant_idx] = 1'b1;
                grant_sel            = req_addr[grant_idx];
            end
        end
    end

    // Pointer moves to the requester just after the winner.
    assign next_ptr = wrap_add(grant_idx, PTR_W'(1));

    // ------------------------------------------------------------------
    // Word captured into the response slice
    // ------------------------------------------------------------------
    logic [N-1:0] capture_word;

`ifdef RF_ARB_BYPASS_EN
    // A same-cycle write to the address being read wins over the stale mux output.
    always_comb begin
        capture_word = rf_data_i;
        if (wr_en_i && (wr_addr_i == grant_sel)) begin
            capture_word = wr_data_i;
        end
    end
`else
    // Without forwarding the read returns the register's old contents.
    always_comb begin
        capture_word = rf_data_i;
    end

    // Write ports are kept for a uniform interface but have no effect here.
    logic unused_wr_ports;
    assign unused_wr_ports = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    // ------------------------------------------------------------------
    // Registered state: pointer, response slices, pulses, busy flag
    // ------------------------------------------------------------------

    // Capture the granted read and advance the pointer; reset clears all.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                rsp_q[k] <= '0;
            end
        end else begin
            rsp_valid_q <= grant_vec;
            busy_q      <= grant_hit;
            if (grant_hit) begin
                rr_ptr           <= next_ptr;
                rsp_q[grant_idx] <= capture_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready_o = grant_vec;
    assign rf_sel_o    = grant_sel;
    assign rsp_valid_o = rsp_valid_q;
    assign busy_o      = busy_q;

endmodule
